score_keeper: RTL and testbench



---
 rtl/score_keeper_pkg.sv | 34 +++
 rtl/digit_font.sv | 37 +++
 rtl/score_keeper.sv | 119 +++++++++++
 tb/tb_score_keeper.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types, geometry constants and BCD helper for the score display.
package score_keeper_pkg;

  localparam int SCORE_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 7;
  localparam int CELL_W  = 12;
  localparam int CELL_H  = 14;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // Adds one to a 4-digit BCD value with a per-digit carry chain (9999 wraps to 0000).
  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/digit_font.sv
// 5x7 glyph ROM for decimal digits 0-9; codes 10-15 and out-of-glyph coordinates are dark.
module digit_font
  import score_keeper_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] gx,
  input  logic [2:0] gy,
  output logic       on
);

  // Row 0 occupies the top five bits; within a row the MSB is the leftmost column.
  logic [GLYPH_W*GLYPH_H-1:0] glyph;
  logic [5:0]                 bit_idx;

  // Select the bitmap for the requested digit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    glyph = '0;
    case (digit)
      4'd0: glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1: glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'd2: glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3: glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4: glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5: glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6: glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7: glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8: glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9: glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: glyph = '0;
    endcase
  end

  assign bit_idx = 6'(GLYPH_W*GLYPH_H-1) - (6'(gy) * 6'(GLYPH_W) + 6'(gx));
  assign on      = (gx < 3'(GLYPH_W)) && (gy < 3'(GLYPH_H)) && glyph[bit_idx];

endmodule

// File: rtl/score_keeper.sv
// Distance score for the dinosaur game: frame-paced BCD score, high score,
// 100-point milestone pulse and a text overlay pixel for the VGA mux.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SCORE_X          = 560,
  parameter int HI_X             = 488,
  parameter int TEXT_Y           = 16
) (
  input  logic        CLK,
  input  logic        clrn,
  input  logic        fresh,
  input  logic        game_status,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        milestone,
  output logic        px
);

  localparam logic [5:0] ACC_LAST  = 6'(FRAMES_PER_POINT - 1);
  localparam logic [9:0] SCORE_COL = 10'(SCORE_X);
  localparam logic [9:0] HI_COL    = 10'(HI_X);
  localparam logic [8:0] TEXT_ROW  = 9'(TEXT_Y);

  logic        fresh_q, gs_q;
  logic [5:0]  acc;
  logic        tick, start_e, stop_e, advance, bump;
  logic [15:0] score_next;

  // vs is active-low, so a frame begins where it falls.
  assign tick       = fresh_q & ~fresh;
  assign start_e    = ~gs_q & game_status;
  assign stop_e     = gs_q & ~game_status;
  assign advance    = tick & game_status & ~start_e;
  assign bump       = advance && (acc == ACC_LAST);
  assign score_next = bcd_inc(score);

  // Edge detectors, frame accumulator, score, high score and milestone pulse.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      fresh_q   <= 1'b1;
      gs_q      <= 1'b0;
      acc       <= '0;
      score     <= '0;
      hi_score  <= '0;
      milestone <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fresh_q   <= fresh;
      gs_q      <= game_status;
      milestone <= 1'b0;
      if (start_e) begin
        score <= '0;
        acc   <= '0;
      end else if (advance) begin
        if (bump) begin
          acc <= '0;
          // Saturated scores stay put and never re-fire the milestone.
          if (score != SCORE_MAX) begin
            score     <= score_next;
            milestone <= (score_next[7:0] == 8'h00);
          end
        end else begin
          acc <= acc + 6'd1;
        end
      end
      // BCD digits order the same way as binary, so a plain compare suffices.
      if (stop_e && (score > hi_score)) begin
        hi_score <= score;
      end
    end
  end

  logic [8:0] row_off;
  logic       row_hit;
  logic [9:0] col_off;
  bcd_t       sel_digit;
  logic [2:0] gx, gy;
  logic       cell_hit, glyph_on;

  assign row_off = row_addr - TEXT_ROW;
  assign row_hit = (row_addr >= TEXT_ROW) && (row_off < 9'(CELL_H));
  assign gy      = row_off[3:1];

  // Find which of the eight digit cells the scan column falls in and pick its digit.
  always_comb begin
    sel_digit = '0;
    col_off   = '0;
    gx        = '0;
    cell_hit  = 1'b0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (col_addr >= SCORE_COL + 10'(CELL_W*i) && col_addr < SCORE_COL + 10'(CELL_W*(i+1))) begin
        col_off   = col_addr - SCORE_COL - 10'(CELL_W*i);
        sel_digit = score[4*(SCORE_DIGITS-1-i) +: 4];
        gx        = 3'(col_off >> 1);
        cell_hit  = 1'b1;
      end
      if (col_addr >= HI_COL + 10'(CELL_W*i) && col_addr < HI_COL + 10'(CELL_W*(i+1))) begin
        col_off   = col_addr - HI_COL - 10'(CELL_W*i);
        sel_digit = hi_score[4*(SCORE_DIGITS-1-i) +: 4];
        gx        = 3'(col_off >> 1);
        cell_hit  = 1'b1;
      end
    end
  end

  digit_font u_font (
    .digit (sel_digit),
    .gx    (gx),
    .gy    (gy),
    .on    (glyph_on)
  );

  assign px = row_hit & cell_hit & (gx < 3'(GLYPH_W)) & (gy < 3'(GLYPH_H)) & glyph_on;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: counting, milestone, high score, start/tick
// priority, overlay pixels and saturation (on a one-frame-per-point instance).
module tb_score_keeper;

  logic        CLK = 1'b0;
  logic        clrn = 1'b0;
  logic        fresh = 1'b1, game_status = 1'b0;
  logic        fresh2 = 1'b1, gs2 = 1'b0;
  logic [8:0]  row_addr = 9'd16;
  logic [9:0]  col_addr = 10'd562;
  logic [15:0] score, hi_score, score2, hi2;
  logic        milestone, px, ms2, px2;

  int total = 0;
  int bad   = 0;
  int ms_count = 0;
  int ms2_count = 0;

  score_keeper u_dut (
    .CLK(CLK), .clrn(clrn), .fresh(fresh), .game_status(game_status),
    .row_addr(row_addr), .col_addr(col_addr),
    .score(score), .hi_score(hi_score), .milestone(milestone), .px(px)
  );

  score_keeper #(.FRAMES_PER_POINT(1)) u_fast (
    .CLK(CLK), .clrn(clrn), .fresh(fresh2), .game_status(gs2),
    .row_addr(row_addr), .col_addr(col_addr),
    .score(score2), .hi_score(hi2), .milestone(ms2), .px(px2)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (milestone) ms_count++;
    if (ms2) ms2_count++;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      fresh = 1'b0; cyc();
      fresh = 1'b1; cyc();
    end
  endtask

  task automatic frames2(input int n);
    repeat (n) begin
      fresh2 = 1'b0; cyc();
      fresh2 = 1'b1; cyc();
    end
  endtask

  task automatic expect16(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    cyc(); cyc();
    expect16("reset_score", score, 16'h0000);
    expect16("reset_hi", hi_score, 16'h0000);
    expect16("reset_milestone", 16'(milestone), 16'h0000);
    expect16("reset_px_zero_glyph", 16'(px), 16'h0001);
    expect16("reset_fast_score", score2, 16'h0000);
  endtask

  task automatic test_count();
    int base;
    clrn = 1'b1; cyc();
    game_status = 1'b1; cyc();
    base = ms_count;
    frames(60);
    expect16("count_60_frames", score, 16'h0010);
    expect16("count_no_milestone", 16'(ms_count - base), 16'h0000);
    frames(5);
    expect16("count_acc_5", score, 16'h0010);
    frames(1);
    expect16("count_acc_wrap", score, 16'h0011);
  endtask

  task automatic test_milestone();
    int base;
    frames(88 * 6);
    expect16("ms_reach_99", score, 16'h0099);
    frames(5);
    expect16("ms_hold_99", score, 16'h0099);
    base = ms_count;
    fresh = 1'b0; cyc();
    expect16("ms_score_100", score, 16'h0100);
    expect16("ms_pulse_high", 16'(milestone), 16'h0001);
    fresh = 1'b1; cyc();
    expect16("ms_pulse_low", 16'(milestone), 16'h0000);
    expect16("ms_pulse_count", 16'(ms_count - base), 16'h0001);
  endtask

  task automatic test_hi_score();
    game_status = 1'b0; cyc();
    expect16("hi_first_game", hi_score, 16'h0100);
    game_status = 1'b1; cyc();
    frames(2);
    #1 clrn = 1'b0;
    #2;
    expect16("clrn_async_score", score, 16'h0000);
    expect16("clrn_async_hi", hi_score, 16'h0000);
    expect16("clrn_async_ms", 16'(milestone), 16'h0000);
    cyc();
    clrn = 1'b1; cyc();
    frames(42 * 6);
    expect16("hi_run_42", score, 16'h0042);
    game_status = 1'b0; cyc();
    expect16("hi_capture_42", hi_score, 16'h0042);
    frames(6);
    expect16("hi_score_held", score, 16'h0042);
    game_status = 1'b1;
    expect16("restart_before_edge", score, 16'h0042);
    cyc();
    expect16("restart_cleared", score, 16'h0000);
    frames(17 * 6);
    expect16("hi_run_17", score, 16'h0017);
    game_status = 1'b0; cyc();
    expect16("hi_keeps_42", hi_score, 16'h0042);
  endtask

  task automatic test_start_tick();
    game_status = 1'b1; cyc();
    frames(30);
    frames(3);
    game_status = 1'b0; cyc();
    expect16("st_pre_score", score, 16'h0005);
    game_status = 1'b1; fresh = 1'b0; cyc();
    expect16("st_start_wins", score, 16'h0000);
    fresh = 1'b1; cyc();
    frames(5);
    expect16("st_acc_cleared", score, 16'h0000);
    frames(1);
    expect16("st_first_point", score, 16'h0001);
  endtask

  task automatic test_toggle();
    game_status = 1'b0; cyc();
    game_status = 1'b1; cyc();
    expect16("toggle_clear", score, 16'h0000);
    game_status = 1'b0; cyc();
    expect16("toggle_score", score, 16'h0000);
    expect16("toggle_hi", hi_score, 16'h0042);
  endtask

  localparam int NPX = 16;
  localparam int PX_ROW [NPX] = '{16, 16, 16, 16, 16, 18, 18, 22, 22, 28, 30, 15, 16, 16, 16, 18};
  localparam int PX_COL [NPX] = '{560, 562, 570, 596, 598, 560, 568, 598, 562, 598, 598, 562, 518, 512, 526, 540};
  localparam int PX_EXP [NPX] = '{0, 1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0};

  task automatic test_px();
    game_status = 1'b1; cyc();
    frames(48);
    expect16("px_score_8", score, 16'h0008);
    for (int i = 0; i < NPX; i++) begin
      row_addr = 9'(PX_ROW[i]);
      col_addr = 10'(PX_COL[i]);
      #1;
      total++;
      if (px !== 1'(PX_EXP[i])) begin
        bad++;
        $display("FAIL px_r%0d_c%0d got=%b want=%0d", PX_ROW[i], PX_COL[i], px, PX_EXP[i]);
      end
    end
  endtask

  task automatic test_saturation();
    gs2 = 1'b1; cyc();
    frames2(9999);
    expect16("sat_reach_9999", score2, 16'h9999);
    expect16("sat_milestones", 16'(ms2_count), 16'd99);
    frames2(12);
    expect16("sat_hold_9999", score2, 16'h9999);
    expect16("sat_no_extra_ms", 16'(ms2_count), 16'd99);
    gs2 = 1'b0; cyc();
    expect16("sat_hi_9999", hi2, 16'h9999);
    row_addr = 9'd16; col_addr = 10'd562; #1;
    expect16("sat_px_nine", 16'(px2), 16'h0001);
  endtask

  initial begin
    test_reset();
    test_count();
    test_milestone();
    test_hi_score();
    test_start_tick();
    test_toggle();
    test_px();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
